// File: rtl/axis_i2c_receiver_if.sv
// AXI4-Stream interface carrying received I2C frames (tdata/tvalid/tready).
interface axis_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_i2c_receiver.sv
// I2C bus receiver: oversamples scl/sda, detects START/STOP, matches a 7-bit
// address, collects data bytes LSB-first and emits {data, rw, addr} on AXIS.
// Optional feature macro: AXIS_I2C_RX_MULTI_EN (multiple data bytes per frame,
// one AXIS word per byte). Without it only the first data byte is accepted.
module axis_i2c_receiver #(
    parameter int unsigned               I2C_ADDR_WIDTH  = 7,
    parameter int unsigned               I2C_DATA_WIDTH  = 8,
    parameter int unsigned               AXIS_DATA_WIDTH = I2C_DATA_WIDTH * 2,
    parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR      = 7'h2A
) (
    input  logic   clk,
    input  logic   arstn,
    input  logic   scl,
    input  logic   sda,
    output logic   sda_oe,
    output logic   busy,
    output logic   overrun,
    axis_if.master m_axis
);

    localparam int unsigned CNT_W = $clog2(AXIS_DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_RW,
        S_ACK_ADDR,
        S_DATA,
        S_ACK_DATA,
        S_WAIT_STOP
    } state_t;

    state_t                       r_state;
    logic [CNT_W-1:0]             r_bit_cnt;
    logic [I2C_ADDR_WIDTH-1:0]    r_addr;
    logic                         r_rw;
    logic [I2C_DATA_WIDTH-1:0]    r_data;
    logic                         r_ack_en;
    logic                         r_ack_armed;
    logic                         r_sda_oe;
    logic                         r_busy;
    logic                         r_overrun;
    logic [AXIS_DATA_WIDTH-1:0]   r_tdata;
    logic                         r_tvalid;

    logic r_scl_meta, r_scl_sync, r_scl_hist;
    logic r_sda_meta, r_sda_sync, r_sda_hist;

    logic                      w_scl_rise;
    logic                      w_scl_fall;
    logic                      w_start;
    logic                      w_stop;
    logic                      w_out_free;
    logic                      w_last_addr;
    logic                      w_last_data;
    logic [I2C_ADDR_WIDTH-1:0] w_addr_next;
    logic [I2C_DATA_WIDTH-1:0] w_data_next;

    // Two-flop synchronizers plus a history flop for edge detection; idle bus is high.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_hist <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_hist <= 1'b1;
        end else begin
            r_scl_meta <= scl;
            r_scl_sync <= r_scl_meta;
            r_scl_hist <= r_scl_sync;
            r_sda_meta <= sda;
            r_sda_sync <= r_sda_meta;
            r_sda_hist <= r_sda_sync;
        end
    end

    assign w_scl_rise  = r_scl_sync & ~r_scl_hist;
    assign w_scl_fall  = ~r_scl_sync & r_scl_hist;
    assign w_start     = r_scl_sync & r_scl_hist & r_sda_hist & ~r_sda_sync;
    assign w_stop      = r_scl_sync & r_scl_hist & ~r_sda_hist & r_sda_sync;
    assign w_out_free  = ~r_tvalid | m_axis.tready;
    assign w_last_addr = (r_bit_cnt == CNT_W'(I2C_ADDR_WIDTH - 1));
    assign w_last_data = (r_bit_cnt == CNT_W'(I2C_DATA_WIDTH - 1));
    // LSB arrives first, so each new bit enters at the top and shifts down.
    assign w_addr_next = {r_sda_sync, r_addr[I2C_ADDR_WIDTH-1:1]};
    assign w_data_next = {r_sda_sync, r_data[I2C_DATA_WIDTH-1:1]};

    // Frame FSM with registered bus/stream outputs.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_addr      <= '0;
            r_rw        <= 1'b0;
            r_data      <= '0;
            r_ack_en    <= 1'b0;
            r_ack_armed <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_tvalid && m_axis.tready) begin
                r_tvalid <= 1'b0;
            end

            if (w_stop) begin
                r_state   <= S_IDLE;
                r_busy    <= 1'b0;
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= '0;
            end else if (w_start) begin
                r_state   <= S_ADDR;
                r_busy    <= 1'b1;
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_sda_oe <= 1'b0;
                    end
                    S_ADDR: begin
                        if (w_scl_rise) begin
                            r_addr <= w_addr_next;
                            if (w_last_addr) begin
                                r_bit_cnt <= '0;
                                r_state   <= S_RW;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    S_RW: begin
                        if (w_scl_rise) begin
                            r_rw        <= r_sda_sync;
                            r_ack_armed <= 1'b0;
                            r_ack_en    <= 1'b1;
                            if (r_addr == SLAVE_ADDR) begin
                                r_state <= S_ACK_ADDR;
                            end else begin
                                r_state <= S_WAIT_STOP;
                            end
                        end
                    end
                    S_ACK_ADDR: begin
                        // First falling edge opens the ACK slot, second closes it.
                        if (w_scl_fall) begin
                            if (!r_ack_armed) begin
                                r_ack_armed <= 1'b1;
                                r_sda_oe    <= r_ack_en;
                            end else begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= '0;
                                r_state   <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (w_scl_rise) begin
                            r_data <= w_data_next;
                            if (w_last_data) begin
                                r_bit_cnt   <= '0;
                                r_ack_armed <= 1'b0;
                                r_state     <= S_ACK_DATA;
                                if (w_out_free) begin
                                    r_tdata  <= AXIS_DATA_WIDTH'({w_data_next, r_rw, r_addr});
                                    r_tvalid <= 1'b1;
                                    r_ack_en <= 1'b1;
                                end else begin
                                    r_overrun <= 1'b1;
                                    r_ack_en  <= 1'b0;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    S_ACK_DATA: begin
                        if (w_scl_fall) begin
                            if (!r_ack_armed) begin
                                r_ack_armed <= 1'b1;
                                r_sda_oe    <= r_ack_en;
                            end else begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= '0;
`ifdef AXIS_I2C_RX_MULTI_EN
                                r_state   <= S_DATA;
`else
                                r_state   <= S_WAIT_STOP;
`endif
                            end
                        end
                    end
                    S_WAIT_STOP: begin
                        r_sda_oe <= 1'b0;
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe        = r_sda_oe;
    assign busy          = r_busy;
    assign overrun       = r_overrun;
    assign m_axis.tdata  = r_tdata;
    assign m_axis.tvalid = r_tvalid;

endmodule

// File: tb/tb_axis_i2c_receiver.sv
// Bench for axis_i2c_receiver: bit-banged I2C master, AXIS monitor and a
// frame-level reference model (expected words/ACKs from address, R/W, bytes).
module tb_axis_i2c_receiver;

    localparam int P = 6;   // scl high phase / data setup, in clk cycles
    localparam int H = 2;   // data hold after scl falls
`ifdef AXIS_I2C_RX_MULTI_EN
    localparam bit MULTI = 1'b1;
`else
    localparam bit MULTI = 1'b0;
`endif

    logic clk = 1'b0;
    logic arstn;
    logic m_scl, m_sda;
    logic sda_bus;
    logic sda_oe, busy, overrun;
    logic fixed_ready, rand_ready, rnd_bit;

    axis_if #(.DATA_WIDTH(16)) axis ();

    assign sda_bus     = m_sda & ~sda_oe;
    assign axis.tready = rand_ready ? rnd_bit : fixed_ready;

    axis_i2c_receiver dut (
        .clk     (clk),
        .arstn   (arstn),
        .scl     (m_scl),
        .sda     (sda_bus),
        .sda_oe  (sda_oe),
        .busy    (busy),
        .overrun (overrun),
        .m_axis  (axis)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int ovr_cnt = 0;
    logic oe_seen = 1'b0;
    logic busy_at_start;
    logic [15:0] obs_q[$];
    logic [15:0] exp_q[$];
    logic hold_prev = 1'b0;
    logic [15:0] prev_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Random tready source for the randomized phase.
    initial begin
        rnd_bit = 1'b1;
        forever begin
            @(posedge clk);
            #1 rnd_bit = 1'($urandom_range(0, 1));
        end
    end

    // AXIS/sideband monitor, sampled on the falling clock edge.
    always @(negedge clk) begin
        if (!arstn) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("axis_hold_valid", 32'(axis.tvalid), 32'd1);
                chk("axis_hold_data", 32'(axis.tdata), 32'(prev_data));
            end
            if (axis.tvalid && axis.tready) obs_q.push_back(axis.tdata);
            if (overrun) ovr_cnt++;
            if (sda_oe) oe_seen = 1'b1;
            hold_prev = axis.tvalid && !axis.tready;
            prev_data = axis.tdata;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        if (m_scl == 1'b0) begin
            m_sda = 1'b1; wait_clk(P);
            m_scl = 1'b1; wait_clk(P);
        end
        m_sda = 1'b0; wait_clk(P);
        m_scl = 1'b0; wait_clk(H);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_clk(P);
        m_scl = 1'b1; wait_clk(P);
        m_sda = 1'b1; wait_clk(P);
    endtask

    task automatic i2c_bit(input logic b, output logic s);
        m_sda = b;    wait_clk(P);
        m_scl = 1'b1; wait_clk(P / 2);
        s = sda_bus;  wait_clk(P - P / 2);
        m_scl = 1'b0; wait_clk(H);
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        logic s;
        for (int i = 0; i < n; i++) i2c_bit(v[3'(i)], s);
    endtask

    task automatic do_frame(input logic [6:0] a, input logic rw, input logic [7:0] d0,
                            input logic [7:0] d1, input logic [7:0] d2, input int nb,
                            output logic ack_a, output logic [2:0] ack_d);
        logic s;
        logic [7:0] d;
        ack_d = '0;
        i2c_start();
        busy_at_start = busy;
        send_bits({1'b0, a}, 7);
        i2c_bit(rw, s);
        i2c_bit(1'b1, s);
        ack_a = ~s;
        for (int i = 0; i < nb; i++) begin
            d = (i == 0) ? d0 : ((i == 1) ? d1 : d2);
            send_bits(d, 8);
            i2c_bit(1'b1, s);
            ack_d[2'(i)] = ~s;
        end
        i2c_stop();
    endtask

    task automatic check_words(input string tag);
        wait_clk(10);
        chk({tag, "_nwords"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk({tag, "_word"}, 32'(obs_q[i]), 32'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic [6:0]  addr;
        logic        rw;
        logic [7:0]  data;
        logic        exp_ack_a;
        logic        exp_ack_d;
        int          exp_n;
        logic [15:0] exp_word;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic       ack_a;
        logic [2:0] ack_d;
        logic       s;

        vecs[0] = '{7'h2A, 1'b0, 8'hA5, 1'b1, 1'b1, 1, 16'hA52A};
        vecs[1] = '{7'h2A, 1'b1, 8'hA5, 1'b1, 1'b1, 1, 16'hA5AA};
        vecs[2] = '{7'h15, 1'b0, 8'h3C, 1'b0, 1'b0, 0, 16'h0000};
        vecs[3] = '{7'h2A, 1'b1, 8'h00, 1'b1, 1'b1, 1, 16'h00AA};
        vecs[4] = '{7'h2A, 1'b0, 8'hFF, 1'b1, 1'b1, 1, 16'hFF2A};
        vecs[5] = '{7'h2B, 1'b1, 8'h81, 1'b0, 1'b0, 0, 16'h0000};

        m_scl = 1'b1; m_sda = 1'b1;
        fixed_ready = 1'b1; rand_ready = 1'b0;
        arstn = 1'b0;
        wait_clk(4);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_tvalid", 32'(axis.tvalid), 32'd0);
        chk("rst_tdata", 32'(axis.tdata), 32'd0);
        arstn = 1'b1;
        wait_clk(5);

        // Table of single-byte frames with tready held high.
        for (int v = 0; v < 6; v++) begin
            oe_seen = 1'b0;
            do_frame(vecs[v].addr, vecs[v].rw, vecs[v].data, 8'h00, 8'h00, 1, ack_a, ack_d);
            chk("tbl_busy_start", 32'(busy_at_start), 32'd1);
            chk("tbl_ack_addr", 32'(ack_a), 32'(vecs[v].exp_ack_a));
            chk("tbl_ack_data", 32'(ack_d[0]), 32'(vecs[v].exp_ack_d));
            chk("tbl_oe_seen", 32'(oe_seen), 32'(vecs[v].exp_ack_a));
            chk("tbl_busy_end", 32'(busy), 32'd0);
            if (vecs[v].exp_n != 0) exp_q.push_back(vecs[v].exp_word);
            check_words("tbl");
        end

        // Two data bytes in one frame: second accepted only with the multi-byte build.
        do_frame(7'h2A, 1'b0, 8'h01, 8'h02, 8'h00, 2, ack_a, ack_d);
        chk("multi_ack_addr", 32'(ack_a), 32'd1);
        chk("multi_ack_d0", 32'(ack_d[0]), 32'd1);
        chk("multi_ack_d1", 32'(ack_d[1]), 32'(MULTI));
        exp_q.push_back(16'h012A);
        if (MULTI) exp_q.push_back(16'h022A);
        check_words("multi");

        // Output stalled: second frame's byte is NACKed and dropped with one overrun pulse.
        fixed_ready = 1'b0;
        ovr_cnt = 0;
        do_frame(7'h2A, 1'b0, 8'h11, 8'h00, 8'h00, 1, ack_a, ack_d);
        chk("stall_ack1", 32'(ack_d[0]), 32'd1);
        do_frame(7'h2A, 1'b0, 8'h22, 8'h00, 8'h00, 1, ack_a, ack_d);
        chk("stall_ack_addr2", 32'(ack_a), 32'd1);
        chk("stall_nack2", 32'(ack_d[0]), 32'd0);
        chk("stall_overrun", 32'(ovr_cnt), 32'd1);
        chk("stall_tvalid", 32'(axis.tvalid), 32'd1);
        chk("stall_tdata", 32'(axis.tdata), 32'h112A);
        fixed_ready = 1'b1;
        exp_q.push_back(16'h112A);
        check_words("stall");
        chk("stall_tvalid_drop", 32'(axis.tvalid), 32'd0);

        // Repeated START after 4 data bits, then a complete frame.
        i2c_start();
        send_bits(8'h2A, 7);
        i2c_bit(1'b0, s);
        i2c_bit(1'b1, s);
        send_bits(8'hF0, 4);
        do_frame(7'h2A, 1'b0, 8'h5A, 8'h00, 8'h00, 1, ack_a, ack_d);
        chk("rstart_ack", 32'(ack_d[0]), 32'd1);
        exp_q.push_back(16'h5A2A);
        check_words("rstart");

        // STOP in the middle of a data byte.
        i2c_start();
        send_bits(8'h2A, 7);
        i2c_bit(1'b0, s);
        i2c_bit(1'b1, s);
        send_bits(8'h07, 3);
        i2c_stop();
        chk("midstop_busy", 32'(busy), 32'd0);
        chk("midstop_oe", 32'(sda_oe), 32'd0);
        check_words("midstop");

        // Reset during the address ACK with a word still pending.
        fixed_ready = 1'b0;
        do_frame(7'h2A, 1'b0, 8'h77, 8'h00, 8'h00, 1, ack_a, ack_d);
        i2c_start();
        send_bits(8'h2A, 7);
        i2c_bit(1'b0, s);
        wait_clk(P);
        chk("ackrst_oe_before", 32'(sda_oe), 32'd1);
        arstn = 1'b0;
        #1;
        chk("ackrst_oe", 32'(sda_oe), 32'd0);
        chk("ackrst_tvalid", 32'(axis.tvalid), 32'd0);
        chk("ackrst_busy", 32'(busy), 32'd0);
        wait_clk(3);
        m_sda = 1'b1; wait_clk(P);
        m_scl = 1'b1; wait_clk(P);
        arstn = 1'b1;
        wait_clk(P);
        obs_q.delete();
        fixed_ready = 1'b1;
        do_frame(7'h2A, 1'b1, 8'hC3, 8'h00, 8'h00, 1, ack_a, ack_d);
        chk("ackrst_next_ack", 32'(ack_d[0]), 32'd1);
        exp_q.push_back(16'hC3AA);
        check_words("ackrst");

        // Randomized frames with random tready against the frame-level model.
        rand_ready = 1'b1;
        for (int f = 0; f < 24; f++) begin
            logic [6:0] a;
            logic       rw;
            logic [7:0] d[3];
            int         nb;
            logic       match;
            a     = ($urandom_range(0, 1) == 1) ? 7'h2A : 7'($urandom);
            rw    = 1'($urandom);
            d[0]  = 8'($urandom); d[1] = 8'($urandom); d[2] = 8'($urandom);
            nb    = $urandom_range(1, 3);
            match = (a == 7'h2A);
            do_frame(a, rw, d[0], d[1], d[2], nb, ack_a, ack_d);
            chk("rnd_ack_addr", 32'(ack_a), 32'(match));
            for (int i = 0; i < nb; i++) begin
                logic take;
                take = match && (i == 0 || MULTI);
                chk("rnd_ack_data", 32'(ack_d[2'(i)]), 32'(take));
                if (take) exp_q.push_back({d[i], rw, a});
            end
            chk("rnd_busy_end", 32'(busy), 32'd0);
            check_words("rnd");
        end
        rand_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
